// File: rtl/timer_cmd_sequencer.sv
// Command FIFO: generic show-ahead synchronous FIFO, DEPTH a power of two.
// Latency: an entry pushed at edge N is presented on pop_dat after edge N.
// Backpressure: push_rdy drops while full; a pop while full frees space the next cycle.
module tcs_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (count != (AW+1)'(DEPTH));
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_rdy && pop_vld;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end
endmodule

// Serialises buffered delay commands to the timer as {PATTERN, delay} MSB first, then supervises the run.
// Latency: a command accepted into an empty FIFO while idle has its first bit on tmr_data one cycle later.
// Backpressure: cmd_ready = FIFO not full; no-start and watchdog expiry raise sticky errors and skip the ack.
module timer_cmd_sequencer #(
    parameter int               DELAY_W        = 4,
    parameter int               PAT_W          = 4,
    parameter logic [PAT_W-1:0] PATTERN        = 4'b1101,
    parameter int               FIFO_DEPTH     = 2,
    parameter int               TIMEOUT_CYCLES = 20000,
    parameter int               GAP_CYCLES     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [DELAY_W-1:0] cmd_delay,
    output logic               cmd_ready,
    output logic               tmr_data,
    output logic               tmr_ack,
    input  logic               tmr_counting,
    input  logic               tmr_done,
    output logic               busy,
    output logic               fire,
    output logic               err_timeout,
    output logic               err_nostart,
    input  logic               err_clr
);
    localparam int FRAME_W = PAT_W + DELAY_W;
    localparam int BC_W    = $clog2(FRAME_W);
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GC_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_START,
        S_WAIT_DONE,
        S_ACK,
        S_GAP
    } state_t;

    state_t               state, state_nxt;
    logic [FRAME_W-1:0]   sr, sr_nxt;
    logic [BC_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic                 start_wait, start_wait_nxt;
    logic [WD_W-1:0]      wd_cnt, wd_cnt_nxt;
    logic [GC_W-1:0]      gap_cnt, gap_cnt_nxt;
    logic                 data_nxt;
    logic                 ack_nxt;
    logic                 set_timeout;
    logic                 set_nostart;
    logic                 pop;
    logic                 fifo_vld;
    logic [DELAY_W-1:0]   fifo_dat;
    logic [FRAME_W-1:0]   frame;

    tcs_fifo #(
        .W     (DELAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .arst_n   (reset),
        .push_vld (cmd_valid),
        .push_rdy (cmd_ready),
        .push_dat (cmd_delay),
        .pop_vld  (fifo_vld),
        .pop_rdy  (pop),
        .pop_dat  (fifo_dat)
    );

    assign frame = {PATTERN, fifo_dat};
    assign busy  = (state != S_IDLE) || fifo_vld;
    assign fire  = tmr_ack;

    always_comb begin
        state_nxt      = state;
        sr_nxt         = sr;
        bit_cnt_nxt    = bit_cnt;
        start_wait_nxt = start_wait;
        wd_cnt_nxt     = wd_cnt;
        gap_cnt_nxt    = gap_cnt;
        data_nxt       = 1'b0;
        ack_nxt        = 1'b0;
        set_timeout    = 1'b0;
        set_nostart    = 1'b0;
        pop            = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_vld) begin
                    // First bit leaves on this edge, so the register keeps only the remainder.
                    pop         = 1'b1;
                    data_nxt    = frame[FRAME_W-1];
                    sr_nxt      = {frame[FRAME_W-2:0], 1'b0};
                    bit_cnt_nxt = '0;
                    state_nxt   = S_SEND;
                end
            end
            S_SEND: begin
                if (bit_cnt == BC_W'(FRAME_W - 1)) begin
                    start_wait_nxt = 1'b0;
                    state_nxt      = S_WAIT_START;
                end else begin
                    data_nxt    = sr[FRAME_W-1];
                    sr_nxt      = {sr[FRAME_W-2:0], 1'b0};
                    bit_cnt_nxt = bit_cnt + BC_W'(1);
                end
            end
            S_WAIT_START: begin
                if (tmr_counting) begin
                    wd_cnt_nxt = '0;
                    state_nxt  = S_WAIT_DONE;
                end else if (start_wait) begin
                    set_nostart = 1'b1;
                    gap_cnt_nxt = '0;
                    state_nxt   = S_GAP;
                end else begin
                    start_wait_nxt = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                // Comparing before the increment: the count would reach the limit on this edge.
                if (tmr_done) begin
                    ack_nxt   = 1'b1;
                    state_nxt = S_ACK;
                end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    set_timeout = 1'b1;
                    gap_cnt_nxt = '0;
                    state_nxt   = S_GAP;
                end else begin
                    wd_cnt_nxt = wd_cnt + WD_W'(1);
                end
            end
            S_ACK: begin
                gap_cnt_nxt = '0;
                state_nxt   = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == GC_W'(GAP_CYCLES - 1)) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GC_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            sr          <= '0;
            bit_cnt     <= '0;
            start_wait  <= 1'b0;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            tmr_data    <= 1'b0;
            tmr_ack     <= 1'b0;
            err_timeout <= 1'b0;
            err_nostart <= 1'b0;
        end else begin
            state       <= state_nxt;
            sr          <= sr_nxt;
            bit_cnt     <= bit_cnt_nxt;
            start_wait  <= start_wait_nxt;
            wd_cnt      <= wd_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            tmr_data    <= data_nxt;
            tmr_ack     <= ack_nxt;
            err_timeout <= set_timeout | (err_timeout & ~err_clr);
            err_nostart <= set_nostart | (err_nostart & ~err_clr);
        end
    end
endmodule

// File: tb/tb_timer_cmd_sequencer.sv
// Scoreboard bench for timer_cmd_sequencer with a behavioural timer model.
// Expected frames/acks/errors are queued at command issue and popped by a negedge monitor.
module tb_timer_cmd_sequencer;
    localparam int         DW   = 4;
    localparam int         TO   = 50;
    localparam int         UNIT = 4;
    localparam logic [3:0] PAT  = 4'b1101;
    localparam int EV_FRAME = 0, EV_ACK = 1, EV_NOSTART = 2, EV_TIMEOUT = 3;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic [DW-1:0] cmd_delay;
    logic          cmd_ready;
    logic          tmr_data;
    logic          tmr_ack;
    logic          tmr_counting;
    logic          tmr_done;
    logic          busy;
    logic          fire;
    logic          err_timeout;
    logic          err_nostart;
    logic          err_clr;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    ev_t  exp_q[$];
    int   run_q[$];
    int   frame_cnt = 0, ack_cnt = 0, spur_cnt = 0;
    int   frame_start_cyc = 0, frame_end_cyc = 0, nostart_cyc = 0, timeout_cyc = 0;
    int   acc_cyc = 0;

    logic       mon_in_frame = 1'b0;
    int         mon_nbits = 0;
    logic [7:0] mon_sh = '0;
    logic       mon_pto = 1'b0, mon_pns = 1'b0;
    int         tm_cnt = 0, tm_seen_f = 0, tm_seen_s = 0, tm_r = 0;

    timer_cmd_sequencer #(
        .DELAY_W        (DW),
        .PAT_W          (4),
        .PATTERN        (PAT),
        .FIFO_DEPTH     (2),
        .TIMEOUT_CYCLES (TO),
        .GAP_CYCLES     (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_delay    (cmd_delay),
        .cmd_ready    (cmd_ready),
        .tmr_data     (tmr_data),
        .tmr_ack      (tmr_ack),
        .tmr_counting (tmr_counting),
        .tmr_done     (tmr_done),
        .busy         (busy),
        .fire         (fire),
        .err_timeout  (err_timeout),
        .err_nostart  (err_nostart),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic got(input int kind, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got kind %0d val 0x%0h, expected no event", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                errors++;
                $display("FAIL scoreboard: got kind %0d val 0x%0h, expected kind %0d val 0x%0h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [DW-1:0] d, input int run, input bit exp_en, output int waited);
        ev_t e;
        waited = 0;
        cmd_valid = 1'b1;
        cmd_delay = d;
        while (!cmd_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_wait: cmd_ready got 0 for %0d cycles, expected 1", waited);
        end
        @(posedge clk);
        if (exp_en) begin
            e.kind = EV_FRAME;
            e.val  = int'({PAT, d});
            exp_q.push_back(e);
            run_q.push_back(run);
            e.val = 0;
            if (run < 0)        e.kind = EV_NOSTART;
            else if (run <= TO) e.kind = EV_ACK;
            else                e.kind = EV_TIMEOUT;
            exp_q.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || tmr_counting || exp_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s: got busy after %0d cycles, expected idle", name, n);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_in_frame = 1'b0;
                mon_nbits = 0;
                mon_pto = 1'b0;
                mon_pns = 1'b0;
            end else begin
                if (mon_in_frame) begin
                    mon_sh = {mon_sh[6:0], tmr_data};
                    mon_nbits++;
                    if (mon_nbits == 8) begin
                        mon_in_frame = 1'b0;
                        frame_cnt++;
                        frame_end_cyc = cyc;
                        got(EV_FRAME, int'(mon_sh));
                    end
                end else if (tmr_data) begin
                    mon_in_frame = 1'b1;
                    mon_nbits = 1;
                    mon_sh = 8'h01;
                    frame_start_cyc = cyc;
                end
                if (tmr_ack || fire) begin
                    chk("fire_eq_ack", int'(fire), int'(tmr_ack));
                    if (tmr_ack) begin
                        ack_cnt++;
                        got(EV_ACK, 0);
                    end
                end
                if (err_nostart && !mon_pns) begin
                    nostart_cyc = cyc;
                    got(EV_NOSTART, 0);
                end
                if (err_timeout && !mon_pto) begin
                    timeout_cyc = cyc;
                    got(EV_TIMEOUT, 0);
                end
                mon_pns = err_nostart;
                mon_pto = err_timeout;
            end
        end
    end

    // Timer model: counting from the cycle after a frame, done pulse after run cycles.
    initial begin : timer_model
        tmr_counting = 1'b0;
        tmr_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tmr_done = 1'b0;
            if (frame_cnt != tm_seen_f) begin
                tm_seen_f = frame_cnt;
                tm_r = (run_q.size() > 0) ? run_q.pop_front() : -1;
                tmr_counting = (tm_r > 0);
                tm_cnt = tm_r;
            end else if (tmr_counting) begin
                if (tm_cnt == 1) begin
                    tmr_done = 1'b1;
                    tmr_counting = 1'b0;
                end else begin
                    tm_cnt--;
                end
            end
            if (spur_cnt != tm_seen_s) begin
                tm_seen_s = spur_cnt;
                tmr_done = 1'b1;
            end
        end
    end

    initial begin : guard
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench stalled");
    end

    initial begin : stimulus
        int w, n, f, seen1;
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_delay = '0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", tmr_data, 0);
        chk("rst_ack", tmr_ack, 0);
        chk("rst_fire", fire, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_to", err_timeout, 0);
        chk("rst_err_ns", err_nostart, 0);
        chk("rst_ready", cmd_ready, 1);
        reset = 1'b1;
        @(negedge clk);

        // Single command
        push(4'd2, UNIT * 3, 1'b1, w);
        chk("t1_wait", w, 0);
        n = acc_cyc;
        wait_idle("t1_idle");
        chk("t1_start_lat", frame_start_cyc - n, 1);
        chk("t1_acks", ack_cnt, 1);
        chk("t1_errs", int'({err_timeout, err_nostart}), 0);

        // Back-to-back commands, FIFO full, 4th waits until first GAP ends
        push(4'd0, UNIT * 1, 1'b1, w);
        chk("t2_push0", w, 0);
        push(4'd5, UNIT * 6, 1'b1, w);
        chk("t2_push1", w, 0);
        push(4'd3, UNIT * 4, 1'b1, w);
        chk("t2_push2", w, 0);
        chk("t2_full", cmd_ready, 0);
        push(4'd9, UNIT * 10, 1'b1, w);
        chk("t2_push3_wait", w, 16);
        wait_idle("t2_idle");
        chk("t2_acks", ack_cnt, 5);

        // Spurious done during SEND
        push(4'd7, UNIT * 8, 1'b1, w);
        repeat (3) @(negedge clk);
        spur_cnt++;
        wait_idle("t6_idle");
        chk("t6_acks", ack_cnt, 6);

        // done on the watchdog limit cycle wins
        push(4'd1, TO, 1'b1, w);
        wait_idle("lim_idle");
        chk("lim_acks", ack_cnt, 7);
        chk("lim_err_to", err_timeout, 0);

        // Timeout one cycle later
        push(4'd4, TO + 1, 1'b1, w);
        wait_idle("t3_idle");
        chk("t3_lat", timeout_cyc - frame_end_cyc, 52);
        chk("t3_acks", ack_cnt, 7);
        chk("t3_err_to", err_timeout, 1);
        push(4'd6, UNIT * 7, 1'b1, w);
        wait_idle("t3_next_idle");
        chk("t3_next_acks", ack_cnt, 8);
        chk("t3_sticky", err_timeout, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t3_clr", err_timeout, 0);

        // No-start with err_clr held: the new event still sets the flag
        err_clr = 1'b1;
        push(4'd3, -1, 1'b1, w);
        n = 0;
        while (!err_nostart && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_seen", err_nostart, 1);
        @(negedge clk);
        chk("t4_gap_busy", busy, 1);
        chk("t4_cleared", err_nostart, 0);
        @(negedge clk);
        chk("t4_idle_busy", busy, 0);
        err_clr = 1'b0;
        chk("t4_lat", nostart_cyc - frame_end_cyc, 3);
        wait_idle("t4_idle");

        // Reset mid-frame at bit 4
        push(4'b1010, 0, 1'b0, w);
        push(4'b0110, 0, 1'b0, w);
        push(4'b0011, 0, 1'b0, w);
        chk("t5_full_before", cmd_ready, 0);
        repeat (3) @(negedge clk);
        chk("t5_bit4", tmr_data, 1);
        #1 reset = 1'b0;
        #1;
        chk("t5_async_data", tmr_data, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_ready", cmd_ready, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        f = frame_cnt;
        seen1 = 0;
        repeat (20) begin
            @(negedge clk);
            if (tmr_data) seen1 = 1;
        end
        chk("t5_no_bits", seen1, 0);
        chk("t5_frames", frame_cnt, f);
        chk("t5_busy", busy, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
